ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//   Two-requester front end for the single-port RAM wrapper (rams): arbitrates port 0 (fetch)
//   and port 1 (load/store) onto one RAM port. Drives ram_ena/we/addr/din, samples ram_dout.
//   Valid/ready handshakes on every request and response channel, one access per cycle,
//   in-order responses per port, round-robin fairness. Sits directly upstream of rams.
// PARAMETERS
//   DATA_  8  data width; must equal rams DATA_
//   ADDR_  8  address width; must equal rams ADDR_
// PORTS
//   clk            in   1      clock, all state on posedge
//   rst            in   1      asynchronous, active-high reset
//   pN_req_valid   in   1      N=0,1: request present
//   pN_req_ready   out  1      request accepted when valid&ready
//   pN_req_we      in   1      1=write, 0=read
//   pN_req_addr    in   ADDR_  word address
//   pN_req_wdata   in   DATA_  write data (ignored for reads)
//   pN_rsp_valid   out  1      response present; held until pN_rsp_ready
//   pN_rsp_ready   in   1      consumer takes response
//   pN_rsp_rdata   out  DATA_  read data; 0 for write acks
//   ram_ena        out  1      RAM enable, high only in access cycle
//   ram_we         out  1      RAM write enable (only meaningful with ram_ena)
//   ram_addr       out  ADDR_  RAM address
//   ram_din        out  DATA_  RAM write data
//   ram_dout       in   DATA_  RAM read data, combinational; 'z when ram_ena=0, never sampled then
// BEHAVIOUR
//   Reset (async): a_vld=0, pN_rsp_valid=0, pN_rsp_rdata=0, rr_ptr=0, ram_ena=0, ram_we=0,
//     ram_addr=0, ram_din=0. In-flight requests are dropped; RAM contents unaffected.
//   Stage A (access reg): a_vld, a_src, a_we, a_addr, a_wdata; holds one accepted request.
//   Stage R (per port): pN_rsp_valid, pN_rsp_rdata.
//   adv = a_vld & (!rsp_valid[a_src] | rsp_ready[a_src])  -- A may issue to RAM this cycle.
//   RAM drive (combinational from stage A only, no input-to-RAM comb path):
//     ram_ena=adv, ram_we=adv&a_we, ram_addr=a_addr, ram_din=a_wdata.
//   On adv: rsp_valid[a_src]<=1, rsp_rdata[a_src]<= a_we ? 0 : ram_dout. Write commits at same edge.
//   Response port without adv: rsp_valid cleared on valid&ready, else held with data stable.
//   Arbitration: slot_free = !a_vld | adv. Both valid -> grant port rr_ptr; one valid -> grant it.
//     pN_req_ready = slot_free & grant==N (ready may depend on valid; never both ready).
//     On handshake: A <= request, a_src=N, rr_ptr <= !N (priority passes to the other port).
//   Latency: handshake in cycle t -> RAM access cycle t+1 (if no stall) -> rsp_valid from t+2.
//   Throughput: one request per cycle when responses are consumed promptly.
//   Backpressure: a stalled response for a_src freezes A and blocks both request ports,
//     including the other port (strict order, no bypass).
//   Ordering/hazards: accesses hit RAM in acceptance order; read after write to same address
//     returns the new data (write commits at edge ending its access cycle).
//   Same-cycle rsp accept + new adv on same port: new response loaded, valid stays 1.
//   Address wrap: none; full 2**ADDR_ space, no range check.
// STRUCTURE
//   Package ram_pkg: typedef ram_req_t {we, addr, wdata}, localparam PORTS=2, port index enum
//     (PORT_FETCH=0, PORT_LSU=1). Parameterised widths are passed via module params.
//   Sub-module rr_arb2: 2-way round-robin arbiter (req[1:0], en, grant[1:0], rr_ptr state,
//     async rst). Top instantiates rr_arb2 only; rams is instantiated by the parent.
// TESTING (bench instantiates rams + ram_port_arbiter, DATA_=8, ADDR_=8)
//   P1 write 0x10<=0xA5, then P0 read 0x10 -> P1 ack rdata=0x00; P0 rsp_rdata=0xA5 at t+2.
//   Both ports valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1, one per cycle.
//   P0 rsp_ready=0 with response pending, P0 issues next read -> A stalls, ram_ena=0,
//     p1_req_ready=0; release rsp_ready -> access proceeds, no response lost or duplicated.
//   Back-to-back P1 write 0xFF<=0x3C then read 0xFF -> rdata=0x3C (RAW, addr at top of range).
//   Assert rst mid-stream with a_vld=1 and rsp pending -> all valids 0 immediately, rr_ptr=0,
//     RAM contents written before reset still read back correctly.
//   Only P1 valid for 5 requests -> P1 granted every cycle, P0 never gets ready.

Source files
------------

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types for the two-port RAM arbiter
package ram_pkg;

  localparam int PORTS      = 2;
  localparam int RAM_DATA_W = 8;
  localparam int RAM_ADDR_W = 8;

  typedef enum logic [0:0] {
    PORT_FETCH = 1'b0,
    PORT_LSU   = 1'b1
  } port_e;

  typedef struct packed {
    logic                  we;
    logic [RAM_ADDR_W-1:0] addr;
    logic [RAM_DATA_W-1:0] wdata;
  } ram_req_t;

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// rtl/ram_port_arbiter_rr_arb2.sv - two-way round-robin arbiter
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] grant_o
);

  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    grant_o  = req_i;
    rr_ptr_d = rr_ptr_q;
    if (req_i == 2'b11) begin
      grant_o = rr_ptr_q ? 2'b10 : 2'b01;
    end
    // A grant only turns into a handshake when the slot is free; priority then passes on.
    if (en_i && (req_i != 2'b00)) begin
      rr_ptr_d = ~grant_o[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - arbitrates fetch and load/store ports onto one RAM port
module ram_port_arbiter
  import ram_pkg::*;
#(
  parameter int DATA_ = RAM_DATA_W,
  parameter int ADDR_ = RAM_ADDR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p0_req_valid,
  output logic             p0_req_ready,
  input  logic             p0_req_we,
  input  logic [ADDR_-1:0] p0_req_addr,
  input  logic [DATA_-1:0] p0_req_wdata,
  output logic             p0_rsp_valid,
  input  logic             p0_rsp_ready,
  output logic [DATA_-1:0] p0_rsp_rdata,
  input  logic             p1_req_valid,
  output logic             p1_req_ready,
  input  logic             p1_req_we,
  input  logic [ADDR_-1:0] p1_req_addr,
  input  logic [DATA_-1:0] p1_req_wdata,
  output logic             p1_rsp_valid,
  input  logic             p1_rsp_ready,
  output logic [DATA_-1:0] p1_rsp_rdata,
  output logic             ram_ena,
  output logic             ram_we,
  output logic [ADDR_-1:0] ram_addr,
  output logic [DATA_-1:0] ram_din,
  input  logic [DATA_-1:0] ram_dout
);

  typedef struct packed {
    logic             we;
    logic [ADDR_-1:0] addr;
    logic [DATA_-1:0] wdata;
  } req_t;

  req_t             req [PORTS];
  logic [PORTS-1:0] req_valid, req_ready, rsp_ready, grant;
  logic             adv, slot_free, take;
  port_e            sel_src;

  logic             a_vld_q, a_vld_d;
  port_e            a_src_q, a_src_d;
  req_t             a_q, a_d;
  logic [PORTS-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_-1:0] rsp_rdata_q [PORTS];
  logic [DATA_-1:0] rsp_rdata_d [PORTS];

  assign req[0]    = {p0_req_we, p0_req_addr, p0_req_wdata};
  assign req[1]    = {p1_req_we, p1_req_addr, p1_req_wdata};
  assign req_valid = {p1_req_valid, p0_req_valid};
  assign rsp_ready = {p1_rsp_ready, p0_rsp_ready};

  // Stage A may only issue when its destination response slot is empty or draining.
  assign adv       = a_vld_q & (~rsp_valid_q[a_src_q] | rsp_ready[a_src_q]);
  assign slot_free = ~a_vld_q | adv;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req_valid),
    .en_i    (slot_free),
    .grant_o (grant)
  );

  assign req_ready    = grant & {PORTS{slot_free}};
  assign take         = |(req_valid & req_ready);
  assign sel_src      = grant[1] ? PORT_LSU : PORT_FETCH;
  assign p0_req_ready = req_ready[0];
  assign p1_req_ready = req_ready[1];

  // RAM is driven from registered stage A only, never straight from request inputs.
  assign ram_ena  = adv;
  assign ram_we   = adv & a_q.we;
  assign ram_addr = a_q.addr;
  assign ram_din  = a_q.wdata;

  always_comb begin
    a_vld_d     = a_vld_q;
    a_src_d     = a_src_q;
    a_d         = a_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    if (adv) begin
      a_vld_d = 1'b0;
    end
    if (take) begin
      a_vld_d = 1'b1;
      a_src_d = sel_src;
      a_d     = req[sel_src];
    end
    for (int p = 0; p < PORTS; p++) begin
      if (rsp_valid_q[p] && rsp_ready[p]) begin
        rsp_valid_d[p] = 1'b0;
      end
    end
    // A new response overrides the consume-clear, so valid stays high back to back.
    if (adv) begin
      rsp_valid_d[a_src_q] = 1'b1;
      rsp_rdata_d[a_src_q] = a_q.we ? '0 : ram_dout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_vld_q     <= 1'b0;
      a_src_q     <= PORT_FETCH;
      a_q         <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '{default: '0};
    end else begin
      a_vld_q     <= a_vld_d;
      a_src_q     <= a_src_d;
      a_q         <= a_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign p0_rsp_valid = rsp_valid_q[0];
  assign p1_rsp_valid = rsp_valid_q[1];
  assign p0_rsp_rdata = rsp_rdata_q[0];
  assign p1_rsp_rdata = rsp_rdata_q[1];

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - scoreboard bench for ram_port_arbiter with a behavioural RAM
module tb_ram_port_arbiter;
  import ram_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       p0_req_valid, p0_req_ready, p0_req_we, p0_rsp_valid, p0_rsp_ready;
  logic       p1_req_valid, p1_req_ready, p1_req_we, p1_rsp_valid, p1_rsp_ready;
  logic [7:0] p0_req_addr, p0_req_wdata, p0_rsp_rdata;
  logic [7:0] p1_req_addr, p1_req_wdata, p1_rsp_rdata;
  logic       ram_ena, ram_we;
  logic [7:0] ram_addr, ram_din;
  wire  [7:0] ram_dout;

  logic [7:0] ram_mem [256];
  logic [7:0] mdl_mem [256];
  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];
  int         grant_log [$];
  int         tests = 0, fails = 0, hs0 = 0, hs1 = 0;
  logic       prio = 1'b0;

  always #5 clk = ~clk;

  assign ram_dout = ram_ena ? ram_mem[ram_addr] : 'z;
  always @(posedge clk) if (ram_ena && ram_we) ram_mem[ram_addr] <= ram_din;

  ram_port_arbiter #(.DATA_(8), .ADDR_(8)) dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_rsp_valid(p0_rsp_valid),
    .p0_rsp_ready(p0_rsp_ready), .p0_rsp_rdata(p0_rsp_rdata),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_rsp_valid(p1_rsp_valid),
    .p1_rsp_ready(p1_rsp_ready), .p1_rsp_rdata(p1_rsp_rdata),
    .ram_ena(ram_ena), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired, required event never came", name);
  endtask

  // Reference memory: accesses take effect in acceptance order, writes ack with 0.
  function automatic logic [7:0] model_access(input ram_req_t r);
    if (r.we) begin
      mdl_mem[r.addr] = r.wdata;
      return 8'h00;
    end
    return mdl_mem[r.addr];
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prio = 1'b0;
    end else begin
      check("ready_exclusive", {31'b0, p0_req_ready & p1_req_ready}, 0);
      if (p0_req_valid && p1_req_valid && (p0_req_ready || p1_req_ready))
        check("rr_grant", {31'b0, p1_req_ready}, {31'b0, prio});
      if (p0_req_valid && p0_req_ready) begin
        exp_q0.push_back(model_access({p0_req_we, p0_req_addr, p0_req_wdata}));
        prio = 1'b1; hs0++; grant_log.push_back(0);
      end
      if (p1_req_valid && p1_req_ready) begin
        exp_q1.push_back(model_access({p1_req_we, p1_req_addr, p1_req_wdata}));
        prio = 1'b0; hs1++; grant_log.push_back(1);
      end
      if (p0_rsp_valid && p0_rsp_ready) begin
        if (exp_q0.size() == 0) fail_now("p0_rsp_unexpected");
        else check("p0_rsp_rdata", p0_rsp_rdata, exp_q0.pop_front());
      end
      if (p1_rsp_valid && p1_rsp_ready) begin
        if (exp_q1.size() == 0) fail_now("p1_rsp_unexpected");
        else check("p1_rsp_rdata", p1_rsp_rdata, exp_q1.pop_front());
      end
    end
  end

  function automatic logic [7:0] rand_addr();
    return 8'($urandom_range(8'hEF, 8'h20));
  endfunction

  task automatic set_req(input int port, input logic v, input logic we,
                         input logic [7:0] addr, input logic [7:0] data);
    if (port == 0) begin
      p0_req_valid = v; p0_req_we = we; p0_req_addr = addr; p0_req_wdata = data;
    end else begin
      p1_req_valid = v; p1_req_we = we; p1_req_addr = addr; p1_req_wdata = data;
    end
  endtask

  task automatic wait_ready(input int port);
    int n = 0;
    forever begin
      @(negedge clk);
      if (port == 0 ? p0_req_ready : p1_req_ready) break;
      if (++n > 100) begin fail_now("req_ready_wait"); break; end
    end
  endtask

  task automatic send(input int port, input logic we, input logic [7:0] addr, input logic [7:0] data);
    set_req(port, 1'b1, we, addr, data);
    wait_ready(port);
    @(posedge clk); #1;
    set_req(port, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic wait_rsp(input int port, output logic [7:0] d);
    int n = 0;
    d = 8'hxx;
    forever begin
      @(negedge clk);
      if (port == 0 && p0_rsp_valid && p0_rsp_ready) begin d = p0_rsp_rdata; break; end
      if (port == 1 && p1_rsp_valid && p1_rsp_ready) begin d = p1_rsp_rdata; break; end
      if (++n > 100) begin fail_now("rsp_wait"); break; end
    end
  endtask

  task automatic wait_rsp_valid0();
    int n = 0;
    forever begin
      @(negedge clk);
      if (p0_rsp_valid) break;
      if (++n > 20) begin fail_now("p0_rsp_valid_wait"); break; end
    end
  endtask

  task automatic drain();
    int n = 0;
    p0_req_valid = 0; p1_req_valid = 0; p0_rsp_ready = 1; p1_rsp_ready = 1;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 100) begin
      @(negedge clk); n++;
    end
    if (exp_q0.size() != 0 || exp_q1.size() != 0) fail_now("drain");
    @(posedge clk); #1;
  endtask

  task automatic run_random(input int cycles, input int pv0, input int pv1,
                            input int pr0, input int pr1);
    logic acc0 = 1'b0, acc1 = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      if (!p0_req_valid || acc0)
        set_req(0, $urandom_range(99) < pv0, 1'($urandom), rand_addr(), 8'($urandom));
      if (!p1_req_valid || acc1)
        set_req(1, $urandom_range(99) < pv1, 1'($urandom), rand_addr(), 8'($urandom));
      p0_rsp_ready = $urandom_range(99) < pr0;
      p1_rsp_ready = $urandom_range(99) < pr1;
      @(negedge clk);
      acc0 = p0_req_valid && p0_req_ready;
      acc1 = p1_req_valid && p1_req_ready;
      @(posedge clk); #1;
    end
    p0_req_valid = 0; p1_req_valid = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int base;
    for (int i = 0; i < 256; i++) begin
      d = 8'($urandom); ram_mem[i] = d; mdl_mem[i] = d;
    end
    rst = 1;
    set_req(0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0);
    p0_rsp_ready = 1; p1_rsp_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_p0_rsp_valid", p0_rsp_valid, 0);
    check("rst_p1_rsp_valid", p1_rsp_valid, 0);
    check("rst_p0_rsp_rdata", p0_rsp_rdata, 0);
    check("rst_p1_rsp_rdata", p1_rsp_rdata, 0);
    check("rst_ram_ena", ram_ena, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_din", ram_din, 0);
    @(posedge clk); #1; rst = 0;

    // write then read of 0x10, with access-cycle and response latency
    send(1, 1, 8'h10, 8'hA5);
    wait_rsp(1, d);
    check("p1_write_ack", d, 8'h00);
    @(posedge clk); #1;
    send(0, 0, 8'h10, 8'h00);
    @(negedge clk);
    check("lat_ram_ena", ram_ena, 1);
    check("lat_ram_we", ram_we, 0);
    check("lat_ram_addr", ram_addr, 8'h10);
    @(negedge clk);
    check("lat_p0_rsp_valid", p0_rsp_valid, 1);
    check("lat_p0_rdata", p0_rsp_rdata, 8'hA5);

    // both ports always valid: one grant per cycle, alternating
    @(posedge clk); #1;
    grant_log.delete();
    base = hs0 + hs1;
    run_random(10, 100, 100, 100, 100);
    check("alt_throughput", hs0 + hs1 - base, 10);
    for (int i = 1; i < grant_log.size(); i++)
      check("alt_grant", grant_log[i], (grant_log[0] + i) % 2);
    drain();

    // stalled P0 response blocks stage A and both request ports
    p0_rsp_ready = 0;
    send(0, 0, 8'h10, 8'h00);
    wait_rsp_valid0();
    @(posedge clk); #1;
    send(0, 0, 8'h30, 8'h00);
    set_req(1, 1, 1, 8'h40, 8'h77);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_ram_ena", ram_ena, 0);
      check("stall_p1_ready", p1_req_ready, 0);
      check("stall_p0_rsp_valid", p0_rsp_valid, 1);
      @(posedge clk); #1;
    end
    p0_rsp_ready = 1;
    @(negedge clk);
    check("release_ram_ena", ram_ena, 1);
    check("release_p1_ready", p1_req_ready, 1);
    @(posedge clk); #1;
    p1_req_valid = 0;
    drain();

    // back-to-back write/read at top address
    set_req(1, 1, 1, 8'hFF, 8'h3C);
    wait_ready(1);
    @(posedge clk); #1;
    set_req(1, 1, 0, 8'hFF, 8'h00);
    wait_ready(1);
    @(posedge clk); #1;
    p1_req_valid = 0;
    wait_rsp(1, d);
    check("raw_write_ack", d, 8'h00);
    wait_rsp(1, d);
    check("raw_read_data", d, 8'h3C);
    drain();

    // only P1 requesting: granted every cycle
    base = hs1;
    for (int i = 0; i < 5; i++) begin
      set_req(1, 1, 1'($urandom), rand_addr(), 8'($urandom));
      @(negedge clk);
      check("p1_only_ready", p1_req_ready, 1);
      check("p1_only_p0_ready", p0_req_ready, 0);
      @(posedge clk); #1;
    end
    p1_req_valid = 0;
    check("p1_only_count", hs1 - base, 5);
    drain();

    run_random(400, 60, 60, 70, 70);
    drain();

    // reset while stage A holds a read and a P0 response is pending
    p0_rsp_ready = 0;
    send(0, 0, 8'h50, 8'h00);
    wait_rsp_valid0();
    @(posedge clk); #1;
    send(0, 0, 8'h51, 8'h00);
    @(negedge clk);
    check("pre_rst_stalled", ram_ena, 0);
    @(posedge clk); #3;
    rst = 1;
    #1;
    check("mid_rst_p0_rsp_valid", p0_rsp_valid, 0);
    check("mid_rst_p1_rsp_valid", p1_rsp_valid, 0);
    check("mid_rst_p0_rdata", p0_rsp_rdata, 0);
    check("mid_rst_ram_ena", ram_ena, 0);
    check("mid_rst_ram_addr", ram_addr, 0);
    exp_q0.delete(); exp_q1.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 0; p0_rsp_ready = 1;
    set_req(0, 1, 0, 8'h10, 8'h00);
    set_req(1, 1, 0, 8'hFF, 8'h00);
    @(negedge clk);
    check("post_rst_p0_first", p0_req_ready, 1);
    check("post_rst_p1_wait", p1_req_ready, 0);
    @(posedge clk); #1;
    p0_req_valid = 0;
    @(negedge clk);
    check("post_rst_p1_next", p1_req_ready, 1);
    @(posedge clk); #1;
    p1_req_valid = 0;
    wait_rsp(0, d);
    check("post_rst_read_10", d, 8'hA5);
    wait_rsp(1, d);
    check("post_rst_read_ff", d, 8'h3C);
    drain();
    check("final_p0_idle", p0_rsp_valid, 0);
    check("final_p1_idle", p1_rsp_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
